// File: rtl/gray_seq_ctrl.sv
// rtl/gray_seq_ctrl.sv - Gray-code sequencer with run/step/load control and valid/ready output
// A binary counter is stepped up or down on each accepted value; its Gray image is kept
// in a register updated alongside it, so gray_out never depends combinationally on inputs.
module gray_seq_ctrl #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             stop,
   input  logic             step,
   input  logic             dir,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   input  logic             out_ready,
   output logic             out_valid,
   output logic [WIDTH-1:0] gray_out,
   output logic [WIDTH-1:0] bin_out,
   output logic             busy,
   output logic             wrap
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_ONE  = 2'd2
   } state_t;

   localparam logic [WIDTH-1:0] CNT_MAX = '1;
   localparam logic [WIDTH-1:0] CNT_ONE = {{(WIDTH-1){1'b0}}, 1'b1};

   state_t           state, state_nxt;
   logic [WIDTH-1:0] bin_q, bin_nxt;
   logic [WIDTH-1:0] gray_q, gray_nxt;
   logic             wrap_q, wrap_nxt;
   logic             xfer;
   logic [WIDTH-1:0] adv_val;
   logic             adv_wrap;

   assign xfer = (state != S_IDLE) && out_ready;

   always_comb begin
      adv_val  = dir ? (bin_q - CNT_ONE) : (bin_q + CNT_ONE);
      adv_wrap = dir ? (bin_q == '0) : (bin_q == CNT_MAX);
   end

   always_comb begin
      state_nxt = state;
      bin_nxt   = bin_q;
      wrap_nxt  = 1'b0;
      case (state)
         S_IDLE: begin
            if (load) begin
               bin_nxt = load_val;
            end else if (start) begin
               state_nxt = S_RUN;
            end else if (step) begin
               state_nxt = S_ONE;
            end
         end
         S_RUN: begin
            // stop still lets a same-cycle transfer complete before leaving RUN
            if (xfer) begin
               bin_nxt  = adv_val;
               wrap_nxt = adv_wrap;
            end
            if (stop) begin
               state_nxt = S_IDLE;
            end
         end
         S_ONE: begin
            if (xfer) begin
               bin_nxt   = adv_val;
               wrap_nxt  = adv_wrap;
               state_nxt = S_IDLE;
            end
         end
         default: begin
            state_nxt = S_IDLE;
         end
      endcase
      gray_nxt = bin_nxt ^ (bin_nxt >> 1);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= S_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bin_q  <= '0;
         gray_q <= '0;
         wrap_q <= 1'b0;
      end else begin
         bin_q  <= bin_nxt;
         gray_q <= gray_nxt;
         wrap_q <= wrap_nxt;
      end
   end

   assign out_valid = (state != S_IDLE);
   assign busy      = (state != S_IDLE);
   assign bin_out   = bin_q;
   assign gray_out  = gray_q;
   assign wrap      = wrap_q;

endmodule

// File: tb/tb_gray_seq_ctrl.sv
// tb/tb_gray_seq_ctrl.sv - Table-driven bench for gray_seq_ctrl (WIDTH=4)
module tb_gray_seq_ctrl;

   logic       clk;
   logic       rst_n;
   logic       start, stop, step, dir, load, out_ready;
   logic [3:0] load_val;
   logic       out_valid, busy, wrap;
   logic [3:0] gray_out, bin_out;

   int n_vec;
   int n_bad;

   gray_seq_ctrl #(.WIDTH(4)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .stop      (stop),
      .step      (step),
      .dir       (dir),
      .load      (load),
      .load_val  (load_val),
      .out_ready (out_ready),
      .out_valid (out_valid),
      .gray_out  (gray_out),
      .bin_out   (bin_out),
      .busy      (busy),
      .wrap      (wrap)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      string      name;
      logic       start, stop, step, dir, load;
      logic [3:0] load_val;
      logic       ready;
      logic       e_valid;
      logic [3:0] e_gray, e_bin;
      logic       e_busy, e_wrap;
   } vec_t;

   vec_t vecs[$];

   // Gray codes of 0..15, written out by hand
   logic [3:0] gray_tab [16] = '{4'h0, 4'h1, 4'h3, 4'h2, 4'h6, 4'h7, 4'h5, 4'h4,
                                 4'hC, 4'hD, 4'hF, 4'hE, 4'hA, 4'hB, 4'h9, 4'h8};

   function automatic void add(string nm, logic st, logic sp, logic sg, logic dr, logic ld,
                               logic [3:0] lv, logic rdy, logic ev, logic [3:0] eg,
                               logic [3:0] eb, logic ebz, logic ew);
      vec_t v;
      v.name = nm; v.start = st; v.stop = sp; v.step = sg; v.dir = dr; v.load = ld;
      v.load_val = lv; v.ready = rdy; v.e_valid = ev; v.e_gray = eg; v.e_bin = eb;
      v.e_busy = ebz; v.e_wrap = ew;
      vecs.push_back(v);
   endfunction

   task automatic check(string nm, logic ev, logic [3:0] eg, logic [3:0] eb, logic ebz, logic ew);
      n_vec++;
      if (out_valid !== ev || gray_out !== eg || bin_out !== eb || busy !== ebz || wrap !== ew) begin
         n_bad++;
         $display("FAIL %s: got valid=%b gray=%b bin=%b busy=%b wrap=%b, want valid=%b gray=%b bin=%b busy=%b wrap=%b",
                  nm, out_valid, gray_out, bin_out, busy, wrap, ev, eg, eb, ebz, ew);
      end
   endtask

   task automatic idle_inputs();
      start = 0; stop = 0; step = 0; dir = 0; load = 0; load_val = 4'h0; out_ready = 0;
   endtask

   initial begin
      n_vec = 0;
      n_bad = 0;
      idle_inputs();
      rst_n = 1'b0;

      //         name         st sp sg dr ld lv  rdy  ev  gray  bin  bz wr
      add("load_over_start",  1, 0, 0, 0, 1, 4'h5, 0,  0, 4'h7, 4'h5, 0, 0);
      add("step_down",        0, 0, 1, 1, 0, 4'h0, 0,  1, 4'h7, 4'h5, 1, 0);
      add("one_stall",        0, 0, 0, 1, 0, 4'h0, 0,  1, 4'h7, 4'h5, 1, 0);
      add("one_xfer",         0, 0, 0, 1, 0, 4'h0, 1,  0, 4'h6, 4'h4, 0, 0);
      add("load_zero",        0, 0, 0, 0, 1, 4'h0, 0,  0, 4'h0, 4'h0, 0, 0);
      add("step_at_zero",     0, 0, 1, 1, 0, 4'h0, 1,  1, 4'h0, 4'h0, 1, 0);
      add("wrap_down",        0, 0, 0, 1, 0, 4'h0, 1,  0, 4'h8, 4'hF, 0, 1);
      add("wrap_clears",      0, 0, 0, 0, 0, 4'h0, 0,  0, 4'h8, 4'hF, 0, 0);
      add("load_zero_b",      0, 0, 0, 0, 1, 4'h0, 0,  0, 4'h0, 4'h0, 0, 0);
      add("start",            1, 0, 0, 0, 0, 4'h0, 0,  1, 4'h0, 4'h0, 1, 0);
      for (int i = 1; i < 16; i++)
         add("run_up",        0, 0, 0, 0, 0, 4'h0, 1,  1, gray_tab[i], 4'(i), 1, 0);
      add("run_wrap_up",      0, 0, 0, 0, 0, 4'h0, 1,  1, 4'h0, 4'h0, 1, 1);
      add("stall_a",          0, 0, 0, 0, 0, 4'h0, 0,  1, 4'h0, 4'h0, 1, 0);
      add("stall_ignores",    0, 0, 1, 0, 1, 4'h9, 0,  1, 4'h0, 4'h0, 1, 0);
      add("resume",           0, 0, 0, 0, 0, 4'h0, 1,  1, 4'h1, 4'h1, 1, 0);
      add("stop_no_xfer",     0, 1, 0, 0, 0, 4'h0, 0,  0, 4'h1, 4'h1, 0, 0);
      add("stop_in_idle",     0, 1, 0, 0, 0, 4'h0, 1,  0, 4'h1, 4'h1, 0, 0);
      add("restart",          1, 0, 0, 0, 0, 4'h0, 0,  1, 4'h1, 4'h1, 1, 0);
      add("start_in_run",     1, 0, 0, 0, 0, 4'h0, 0,  1, 4'h1, 4'h1, 1, 0);
      add("stop_with_xfer",   0, 1, 0, 0, 0, 4'h0, 1,  0, 4'h3, 4'h2, 0, 0);
      add("restart_b",        1, 0, 0, 0, 0, 4'h0, 0,  1, 4'h3, 4'h2, 1, 0);
      add("dir_flip_1",       0, 0, 0, 1, 0, 4'h0, 1,  1, 4'h1, 4'h1, 1, 0);
      add("dir_flip_0",       0, 0, 0, 1, 0, 4'h0, 1,  1, 4'h0, 4'h0, 1, 0);
      add("run_wrap_down",    0, 0, 0, 1, 0, 4'h0, 1,  1, 4'h8, 4'hF, 1, 1);
      add("run_wrap_up_b",    0, 0, 0, 0, 0, 4'h0, 1,  1, 4'h0, 4'h0, 1, 1);
      add("up_to_one",        0, 0, 0, 0, 0, 4'h0, 1,  1, 4'h1, 4'h1, 1, 0);
      add("hold_for_reset",   0, 0, 0, 0, 0, 4'h0, 0,  1, 4'h1, 4'h1, 1, 0);

      repeat (2) @(posedge clk);
      #1;
      check("reset_state", 0, 4'h0, 4'h0, 0, 0);
      @(negedge clk);
      rst_n = 1'b1;

      foreach (vecs[k]) begin
         @(negedge clk);
         start = vecs[k].start; stop = vecs[k].stop; step = vecs[k].step;
         dir = vecs[k].dir; load = vecs[k].load; load_val = vecs[k].load_val;
         out_ready = vecs[k].ready;
         @(posedge clk);
         #1;
         check(vecs[k].name, vecs[k].e_valid, vecs[k].e_gray, vecs[k].e_bin,
               vecs[k].e_busy, vecs[k].e_wrap);
      end

      // asynchronous reset mid-handshake, sampled between clock edges
      #2;
      rst_n = 1'b0;
      #1;
      check("async_reset", 0, 4'h0, 4'h0, 0, 0);
      @(negedge clk);
      idle_inputs();
      rst_n = 1'b1;

      // step from reset with a bounded wait for the offered value
      @(negedge clk);
      step = 1'b1;
      begin
         int cyc;
         cyc = 0;
         do begin
            @(posedge clk);
            #1;
            cyc++;
         end while (!out_valid && cyc < 4);
         n_vec++;
         if (!out_valid || cyc != 1) begin
            n_bad++;
            $display("FAIL step_latency: got valid after %0d cycles (valid=%b), want 1", cyc, out_valid);
         end
      end
      check("step_after_reset", 1, 4'h0, 4'h0, 1, 0);
      @(negedge clk);
      step = 1'b0;
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      check("step_after_reset_xfer", 0, 4'h1, 4'h1, 0, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule

// File: doc/gray_seq_ctrl.md
Name: gray_seq_ctrl

Overview:
Sequencer that generates a stream of Gray-coded values for downstream logic. It owns a binary counter and converts it to Gray (G = B ^ (B >> 1)). It steps the counter up or down under run, single-step and load control. Values are delivered over a valid/ready handshake, and the block flags wrap-around so consumers (pointer sync, position encoders) see exactly one bit change per accepted value.

Parameters:
WIDTH, 4, counter and code width in bits (>= 2)

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  begin continuous run (sampled in IDLE)
stop  input  1  end continuous run (sampled in RUN)
step  input  1  emit exactly one value (sampled in IDLE)
dir  input  1  0 = count up, 1 = count down; sampled at each advance
load  input  1  load counter from load_val (IDLE only)
load_val  input  WIDTH  binary value to load
out_ready  input  1  consumer accepts current value
out_valid  output  1  gray_out/bin_out hold a valid value
gray_out  output  WIDTH  Gray code of current counter
bin_out  output  WIDTH  current binary counter value
busy  output  1  state != IDLE
wrap  output  1  one-cycle pulse: last advance wrapped (max->0 up, 0->max down)

Behaviour:
- One clock; reset is asynchronous and active-low (rst_n); all registers clocked on clk rising edge.
- Reset (rst_n=0, any time, including mid-handshake): state=IDLE, counter=0, gray_out=0, bin_out=0, out_valid=0, busy=0, wrap=0. The value being offered is dropped and no handshake completes.
- gray_out is registered and always equals bin_out ^ (bin_out >> 1) in the same cycle; never combinationally derived from inputs.
- Handshake: transfer occurs on a cycle with out_valid=1 and out_ready=1. While out_valid=1 and out_ready=0, gray_out/bin_out hold stable and the counter does not advance.
- States:
  - IDLE: out_valid=0. Input priority load > start > step.
    - load=1: counter <= load_val next cycle; stay IDLE; wrap=0.
    - start=1: go RUN.
    - step=1: go ONE.
  - RUN: out_valid=1. On transfer, counter advances by +1 (dir=0) or -1 (dir=1) modulo 2^WIDTH, so back-to-back transfers give one value per cycle. stop=1 with no transfer: go IDLE, counter unchanged. stop=1 with a transfer in the same cycle: the transfer completes, the counter advances, and the state goes to IDLE.
  - ONE: out_valid=1. On transfer, advance per dir and go IDLE.
- Latency: start/step asserted in cycle n gives out_valid=1 in cycle n+1, carrying the counter value present at cycle n.
- wrap=1 in the cycle after an advance from 2^WIDTH-1 to 0 (up) or from 0 to 2^WIDTH-1 (down); 0 otherwise.
- Inputs are ignored outside their legal states:
  - load in RUN/ONE: ignored.
  - start/step outside IDLE: ignored.
  - stop outside RUN: ignored.
- dir changes mid-run take effect at the next advance. Consecutive accepted gray_out values differ in exactly one bit, except across a load.
- No internal stall other than out_ready; no overflow or error state.

Test Plan:
1. Reset then start, out_ready=1, dir=0, WIDTH=4 -> gray_out accepted sequence 0000,0001,0011,0010,0110, ..., 1000, then 0000 with wrap=1 in the cycle after the advance from 1111.
2. load=1, load_val=0101 in IDLE, then step, dir=1 -> single transfer of bin 0101 / gray 0111, counter becomes 0100, state returns IDLE, busy=0.
3. RUN with out_ready toggling 1,0,0,1 -> gray_out held stable during the two stalled cycles; accepted values are consecutive and differ by one bit.
4. Counter at 0, dir=1, step -> transfer gray 0000, counter becomes 1111 (gray 1000), wrap=1 for exactly one cycle.
5. RUN: stop and a handshake in the same cycle -> that value is accepted, the counter advances once, and out_valid=0 next cycle. Separately, stop with out_ready=0 -> counter is unchanged.
6. rst_n pulsed low mid-RUN with out_valid=1, out_ready=0 -> outputs immediately 0 with no clock edge needed; start and load in the same cycle in IDLE -> only the load takes effect.
